// File: rtl/button_press_classifier.sv
// Classifies a debounced button into short, long and double presses.
// All outputs are registered; pulses appear one cycle after the deciding FSM transition.
module button_press_classifier #(
  parameter int LONG_CYCLES       = 50_000_000,
  parameter int DOUBLE_GAP_CYCLES = 25_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  localparam int MAX_CYCLES = (LONG_CYCLES > DOUBLE_GAP_CYCLES) ? LONG_CYCLES : DOUBLE_GAP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(DOUBLE_GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESSED1    = 2'd1,
    WAIT_SECOND = 2'd2,
    HELD        = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          btn_prev;
  logic          rise;

  // Pulse requests raised on the transition edge; re-registered into the outputs.
  logic short_req, long_req, double_req;
  logic short_req_q, long_req_q, double_req_q;

  assign rise = btn_in & ~btn_prev;

  always_comb begin
    state_nxt  = state;
    short_req  = 1'b0;
    long_req   = 1'b0;
    double_req = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_nxt = PRESSED1;
      end
      PRESSED1: begin
        if (!btn_in) begin
          state_nxt = WAIT_SECOND;
        end else if (cnt == LONG_LAST) begin
          state_nxt = HELD;
          long_req  = 1'b1;
        end
      end
      WAIT_SECOND: begin
        // A second press wins over gap expiry landing on the same cycle.
        if (rise) begin
          state_nxt  = HELD;
          double_req = 1'b1;
        end else if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          short_req = 1'b1;
        end
      end
      HELD: begin
        if (!btn_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if ((state == PRESSED1) || (state == WAIT_SECOND)) begin
      if (cnt != CNT_SAT) cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      cnt          <= '0;
      btn_prev     <= 1'b0;
      short_req_q  <= 1'b0;
      long_req_q   <= 1'b0;
      double_req_q <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      btn_prev     <= btn_in;
      short_req_q  <= short_req;
      long_req_q   <= long_req;
      double_req_q <= double_req;
      short_press  <= short_req_q;
      long_press   <= long_req_q;
      double_press <= double_req_q;
      busy         <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed checks of press classification, latency, reset behaviour and pulse exclusivity.
module tb_button_press_classifier;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic btn_in = 1'b0;
  logic short_press, long_press, double_press, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  button_press_classifier #(
    .LONG_CYCLES      (8),
    .DOUBLE_GAP_CYCLES(6)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .btn_in      (btn_in),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .busy        (busy)
  );

  task automatic tick(input logic b, input logic r);
    btn_in = b;
    rst_in = r;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, k, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int k,
                           input logic es, input logic el, input logic ed, input logic eb);
    chk({tag, ".short"},  k, short_press,  es);
    chk({tag, ".long"},   k, long_press,   el);
    chk({tag, ".double"}, k, double_press, ed);
    chk({tag, ".busy"},   k, busy,         eb);
  endtask

  task automatic settle();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    logic b, ps, pl, pd;
    int   npulse;

    // Reset state
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    check_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // Short press: high 0-2, release sampled at 3, short in cycle 10
    settle();
    for (int k = 0; k <= 16; k++) begin
      tick(k <= 2, 1'b0);
      check_all("short", k, k == 10, 1'b0, 1'b0, (k >= 1) && (k <= 9));
    end

    // Long press: high 0-20, long in cycle 9, busy drops at 22
    settle();
    for (int k = 0; k <= 26; k++) begin
      tick(k <= 20, 1'b0);
      check_all("long", k, 1'b0, k == 9, 1'b0, (k >= 1) && (k <= 21));
    end

    // Double press: high 0-2, low 3-5, high 6-9, double in cycle 7
    settle();
    for (int k = 0; k <= 20; k++) begin
      tick((k <= 2) || ((k >= 6) && (k <= 9)), 1'b0);
      check_all("double", k, 1'b0, 1'b0, k == 7, (k >= 1) && (k <= 10));
    end

    // Gap boundary: second rise on the expiry cycle 9, double in cycle 10
    settle();
    for (int k = 0; k <= 20; k++) begin
      tick((k <= 2) || ((k >= 9) && (k <= 11)), 1'b0);
      check_all("gapedge", k, 1'b0, 1'b0, k == 10, (k >= 1) && (k <= 12));
    end

    // Third press after a double press starts fresh: short after its own gap
    settle();
    for (int k = 0; k <= 30; k++) begin
      tick((k <= 1) || ((k >= 4) && (k <= 5)) || ((k >= 10) && (k <= 11)), 1'b0);
      check_all("third", k, k == 19, 1'b0, k == 5, ((k >= 1) && (k <= 6)) || ((k >= 11) && (k <= 18)));
    end

    // Reset mid-press at cycle 4; post-reset rise at 5 gives long at 14
    settle();
    for (int k = 0; k <= 20; k++) begin
      tick(1'b1, k == 4);
      check_all("rstmid", k, 1'b0, k == 14, 1'b0, ((k >= 1) && (k <= 3)) || (k >= 6));
    end

    // Reset during the gap discards the pending short press
    settle();
    for (int k = 0; k <= 16; k++) begin
      tick(k <= 2, k == 5);
      check_all("rstgap", k, 1'b0, 1'b0, 1'b0, (k >= 1) && (k <= 4));
    end

    // Random stream: exclusivity and single-cycle width
    settle();
    b  = 1'b0;
    ps = 1'b0;
    pl = 1'b0;
    pd = 1'b0;
    for (int k = 0; k < 12000; k++) begin
      if ($urandom_range(0, 5) == 0) b = ~b;
      tick(b, 1'b0);
      npulse = int'(short_press) + int'(long_press) + int'(double_press);
      chk("rand.onehot", k, npulse <= 1, 1'b1);
      chk("rand.width", k, (ps & short_press) | (pl & long_press) | (pd & double_press), 1'b0);
      ps = short_press;
      pl = long_press;
      pd = double_press;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
